// File: rtl/async_fifo_pkg.sv
// Shared types and Gray-code helpers for the dual-clock FIFO pointer logic.
// Both the read and write side controllers import this package.
package async_fifo_pkg;

  localparam int MAX_LENGTH = 32;

  typedef logic [MAX_LENGTH-1:0] ptr_word_t;

  typedef struct packed {
    logic empty;
    logic almost_empty;
    logic underflow;
    logic overrun_err;
  } fifo_rd_status_t;

  localparam fifo_rd_status_t RD_STATUS_RESET = '{
    empty:        1'b1,
    almost_empty: 1'b1,
    underflow:    1'b0,
    overrun_err:  1'b0
  };

  function automatic ptr_word_t width_mask(input int length);
    if (length >= MAX_LENGTH) return '1;
    return (ptr_word_t'(1) << length) - ptr_word_t'(1);
  endfunction

  // g = b ^ (b >> 1), limited to the low 'length' bits.
  function automatic ptr_word_t bin2gray(input ptr_word_t b, input int length);
    ptr_word_t bm;
    bm = b & width_mask(length);
    return bm ^ (bm >> 1);
  endfunction

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  function automatic ptr_word_t gray2bin(input ptr_word_t g, input int length);
    ptr_word_t gm;
    ptr_word_t b;
    gm = g & width_mask(length);
    b  = '0;
    for (int i = 0; i < MAX_LENGTH; i++) begin
      b[i] = ^(gm >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder, shared by the read and write side
// pointer controllers to interpret the pointer synchronized from the other side.
module gray_to_binary #(
  parameter int LENGTH = 8
) (
  input  logic [LENGTH-1:0] gray_i,
  output logic [LENGTH-1:0] bin_o
);

  // A flat reduction per bit keeps the decoder free of bit-to-bit feedback
  // within one vector, so it stays a pure tree of XORs.
  for (genvar i = 0; i < LENGTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[LENGTH-1:i];
  end

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side pointer and flag controller of a dual-clock FIFO (clk_diff domain):
// owns the read pointer, drives the RAM read port and derives empty/level flags.
module async_fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int LENGTH          = 8,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic              clk_diff,
  input  logic              reset_diff,
  input  logic [LENGTH-1:0] wr_gray_synced,
  input  logic              rd_en,
  output logic              rd_accept,
  output logic              mem_rd_en,
  output logic [LENGTH-2:0] mem_rd_addr,
  output logic              data_valid,
  output logic [LENGTH-1:0] rd_gray,
  output logic              empty,
  output logic              almost_empty,
  output logic [LENGTH-1:0] level,
  output logic              underflow,
  output logic              overrun_err
);

  localparam logic [LENGTH-1:0] DEPTH_L = {1'b1, {(LENGTH-1){1'b0}}};
  localparam logic [LENGTH-1:0] TH_L    = LENGTH'(ALMOST_EMPTY_TH);

  logic [LENGTH-1:0] wr_bin;

  logic [LENGTH-1:0] rd_bin_q,     rd_bin_d;
  logic [LENGTH-1:0] rd_gray_q,    rd_gray_d;
  logic [LENGTH-1:0] level_q,      level_d;
  logic              data_valid_q, data_valid_d;
  fifo_rd_status_t   status_q,     status_d;

  gray_to_binary #(
    .LENGTH (LENGTH)
  ) u_wr_decode (
    .gray_i (wr_gray_synced),
    .bin_o  (wr_bin)
  );

  // The pop is gated by the registered empty flag only, so a pop in this
  // cycle is already folded into the level that empty will be built from.
  always_comb begin
    // NOTE: every always_comb target gets a value before any other statement,
    // so no path can leave one unassigned and infer a latch.
    rd_bin_d     = rd_bin_q;
    rd_gray_d    = rd_gray_q;
    level_d      = level_q;
    data_valid_d = 1'b0;
    status_d     = status_q;
    rd_accept    = rd_en & ~status_q.empty;

    rd_bin_d     = rd_bin_q + {{(LENGTH-1){1'b0}}, rd_accept};
    rd_gray_d    = LENGTH'(bin2gray(ptr_word_t'(rd_bin_d), LENGTH));
    level_d      = wr_bin - rd_bin_d;
    data_valid_d = rd_accept;

    // Corrupt synchronization is flagged but the raw difference still drives
    // the flags, so the symptom stays visible rather than being masked.
    status_d.empty        = (level_d == '0);
    status_d.almost_empty = (level_d <= TH_L);
    status_d.underflow    = rd_en & status_q.empty;
    status_d.overrun_err  = status_q.overrun_err | (level_d > DEPTH_L);
  end

  always_ff @(posedge clk_diff) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this clock edge, whatever the order.
    if (reset_diff) begin
      rd_bin_q     <= '0;
      rd_gray_q    <= '0;
      level_q      <= '0;
      data_valid_q <= 1'b0;
      status_q     <= RD_STATUS_RESET;
    end else begin
      rd_bin_q     <= rd_bin_d;
      rd_gray_q    <= rd_gray_d;
      level_q      <= level_d;
      data_valid_q <= data_valid_d;
      status_q     <= status_d;
    end
  end

  assign mem_rd_en    = rd_accept;
  assign mem_rd_addr  = rd_bin_q[LENGTH-2:0];
  assign data_valid   = data_valid_q;
  assign rd_gray      = rd_gray_q;
  assign level        = level_q;
  assign empty        = status_q.empty;
  assign almost_empty = status_q.almost_empty;
  assign underflow    = status_q.underflow;
  assign overrun_err  = status_q.overrun_err;

endmodule
